// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and per-stage constants for pipeline stage registers
// Purpose: state encoding for pipe_stage_reg plus the control/data widths and
//          bubble control values of the classic five-stage pipeline boundaries.
// Ports:   none (package).
package pipe_pkg;

   // Encoding equals the number of beats held, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

   localparam int IF_ID_CTRL_W  = 4;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 10;
   localparam int ID_EX_DATA_W  = 128;
   localparam int EX_MEM_CTRL_W = 6;
   localparam int EX_MEM_DATA_W = 106;
   localparam int MEM_WB_CTRL_W = 3;
   localparam int MEM_WB_DATA_W = 69;

   // Bubbles carry no write/memory enables; all control fields zero.
   localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_BUBBLE_CTRL  = '0;
   localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_BUBBLE_CTRL  = '0;
   localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE_CTRL = '0;
   localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_entry.sv
// rtl/pipe_stage_entry.sv - one ctrl+data holding register with load and bubble-on-clear
// Purpose: storage for one pipeline beat.
// Ports:   clk, rst (sync, active-high: ctrl=bubble, data=0)
//          clear   - force ctrl to bubble, data kept
//          load    - capture in_ctrl/in_data (clear wins)
//          in_ctrl/in_data -> ctrl/data registered outputs
module pipe_stage_entry #(
   parameter int                CTRL_W      = 10,
   parameter int                DATA_W      = 128,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= BUBBLE_CTRL;
         data <= '0;
      end else if (clear) begin
         ctrl <= BUBBLE_CTRL;
      end else if (load) begin
         ctrl <= in_ctrl;
         data <= in_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready inter-stage pipeline register
// Purpose: carries a control and data bundle between pipeline stages, with
//          optional 2-entry skid buffer, flush-to-bubble and a stall counter.
// Ports:   clk, rst (sync, active-high), flush
//          in_valid/in_ready/in_ctrl/in_data    - upstream beat
//          out_valid/out_ready/out_ctrl/out_data - downstream beat (head)
//          occupancy - beats held; stall_cnt - saturating valid&!ready cycles
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                CTRL_W      = 10,
   parameter int                DATA_W      = 128,
   parameter int                SKID        = 1,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_t      state, state_nxt;
   logic              valid_q, rdy_q;
   logic              push, pop;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [CTRL_W-1:0] main_src_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_src_data, skid_data;

   // With a skid slot, ready is a pure flop so it never chains through stages.
   assign in_ready  = (SKID != 0) ? rdy_q : (!valid_q || out_ready);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = valid_q && out_ready;
   assign out_valid = valid_q;
   assign occupancy = state;

   always_comb begin
      state_nxt = state;
      main_load = 1'b0;
      skid_load = 1'b0;
      case (state)
         ST_EMPTY: if (push) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
         end
         ST_ONE: begin
            if (push && !pop && SKID != 0) begin
               state_nxt = ST_TWO;
               skid_load = 1'b1;
            end else if (push && pop) begin
               main_load = 1'b1;
            end else if (pop) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: if (pop) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
         end
         default: state_nxt = ST_EMPTY;
      endcase
      if (flush) state_nxt = ST_EMPTY;
   end

   // Main refills from skid when draining TWO; otherwise from upstream.
   assign main_src_ctrl = (state == ST_TWO) ? skid_ctrl : in_ctrl;
   assign main_src_data = (state == ST_TWO) ? skid_data : in_data;
   // Going empty for any reason forces the bubble so out_ctrl is safe while invalid.
   assign main_clear    = (state_nxt == ST_EMPTY);
   assign skid_clear    = flush || (state == ST_TWO && pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         valid_q   <= 1'b0;
         rdy_q     <= 1'b1;
         stall_cnt <= '0;
      end else begin
         state   <= state_nxt;
         valid_q <= (state_nxt != ST_EMPTY);
         rdy_q   <= (state_nxt != ST_TWO);
         if (valid_q && !out_ready && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   pipe_stage_entry #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)
   ) u_main (
      .clk(clk), .rst(rst), .clear(main_clear), .load(main_load),
      .in_ctrl(main_src_ctrl), .in_data(main_src_data),
      .ctrl(out_ctrl), .data(out_data)
   );

   if (SKID != 0) begin : g_skid
      pipe_stage_entry #(
         .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)
      ) u_skid (
         .clk(clk), .rst(rst), .clear(skid_clear), .load(skid_load),
         .in_ctrl(in_ctrl), .in_data(in_data),
         .ctrl(skid_ctrl), .data(skid_data)
      );
   end else begin : g_no_skid
      logic unused_skid_ctl;
      assign skid_ctrl       = '0;
      assign skid_data       = '0;
      assign unused_skid_ctl = skid_load ^ skid_clear;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (SKID=1 and SKID=0)
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [9:0]   c;
      logic [127:0] d;
   } beat_t;

   localparam logic [9:0] BUB0 = 10'h000;
   localparam logic [9:0] BUB1 = 10'h155;
   localparam int         SMAX = 15;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [9:0]   in_ctrl;
   logic [127:0] in_data;

   logic         i_ready [2];
   logic         o_valid [2];
   logic [9:0]   o_ctrl  [2];
   logic [127:0] o_data  [2];
   logic [1:0]   occ     [2];
   logic [3:0]   stall   [2];

   beat_t sb [2][16];
   int    wr [2], rd [2], cnt [2], m_stall [2];
   int    n_vec = 0, n_err = 0;
   bit    started = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(10), .DATA_W(128), .SKID(1), .BUBBLE_CTRL(BUB0), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(i_ready[0]),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_valid[0]), .out_ready(out_ready),
      .out_ctrl(o_ctrl[0]), .out_data(o_data[0]), .occupancy(occ[0]), .stall_cnt(stall[0]));

   pipe_stage_reg #(.CTRL_W(10), .DATA_W(128), .SKID(0), .BUBBLE_CTRL(BUB1), .CNT_W(4)) u_noskid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(i_ready[1]),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_valid[1]), .out_ready(out_ready),
      .out_ctrl(o_ctrl[1]), .out_data(o_data[1]), .occupancy(occ[1]), .stall_cnt(stall[1]));

   // Capacity rule: two beats with a skid slot, one without (then freed by a same-cycle pop).
   function automatic bit model_ready(input int k);
      return (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || out_ready);
   endfunction

   task automatic check(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
      end
   endtask

   // Reference model: advances at each edge on the pre-edge inputs; accepted beats go to the scoreboard.
   always @(posedge clk) begin
      started = 1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            cnt[k] = 0; m_stall[k] = 0; rd[k] = wr[k];
         end else begin
            bit pu, po;
            if (cnt[k] > 0 && !out_ready && !flush && m_stall[k] < SMAX) m_stall[k]++;
            if (flush) begin
               cnt[k] = 0; rd[k] = wr[k];
            end else begin
               po = (cnt[k] > 0) && out_ready;
               pu = in_valid && model_ready(k);
               if (pu) begin
                  sb[k][wr[k] % 16] = '{c: in_ctrl, d: in_data};
                  wr[k]++;
               end
               cnt[k] = cnt[k] + int'(pu) - int'(po);
            end
         end
      end
   end

   // Monitor: status checks every cycle, scoreboard pop whenever the DUT hands a beat downstream.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            check("occupancy", k, 128'(occ[k]), 128'(cnt[k]));
            check("out_valid", k, 128'(o_valid[k]), 128'(cnt[k] != 0));
            check("in_ready", k, 128'(i_ready[k]), 128'(model_ready(k)));
            check("stall_cnt", k, 128'(stall[k]), 128'(m_stall[k]));
            if (cnt[k] == 0) check("bubble_ctrl", k, 128'(o_ctrl[k]), 128'(k == 0 ? BUB0 : BUB1));
            if (o_valid[k] && out_ready && !flush && !rst) begin
               check("sb_nonempty", k, 128'(wr[k] > rd[k]), 128'(1));
               if (wr[k] > rd[k]) begin
                  check("out_ctrl", k, 128'(o_ctrl[k]), 128'(sb[k][rd[k] % 16].c));
                  check("out_data", k, o_data[k], sb[k][rd[k] % 16].d);
                  rd[k]++;
               end
            end
         end
      end
   end

   task automatic drive(input logic iv, input logic [127:0] d, input logic ordy, input logic fl, input int n);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = d[9:0] ^ 10'h2A0;
      out_ready = ordy;
      flush     = fl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         wr[k] = 0; rd[k] = 0; cnt[k] = 0; m_stall[k] = 0;
      end
      rst = 1; flush = 0; out_ready = 0; in_valid = 1; in_ctrl = 10'h3FF; in_data = '1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      // streaming
      drive(1, 128'hA, 1, 0, 1);
      drive(1, 128'hB, 1, 0, 1);
      drive(1, 128'hC, 1, 0, 1);
      drive(0, 0, 1, 0, 2);
      // backpressure then drain
      drive(1, 128'h1, 0, 0, 1);
      drive(1, 128'h2, 0, 0, 1);
      drive(0, 0, 0, 0, 4);
      drive(0, 0, 1, 0, 3);
      // flush while full, with a coincident offered beat and pop
      drive(1, 128'h7, 0, 0, 1);
      drive(1, 128'h8, 0, 0, 1);
      drive(1, 128'h9, 1, 1, 1);
      drive(0, 0, 1, 0, 2);
      // stalled single entry, then pop with same-cycle push
      drive(1, 128'h4, 0, 0, 1);
      drive(0, 0, 0, 0, 2);
      drive(1, 128'h5, 1, 0, 1);
      drive(0, 0, 1, 0, 2);
      // saturation: fresh counter, long stall, flush, stall again
      rst = 1;
      drive(0, 0, 0, 0, 1);
      rst = 0;
      drive(1, 128'h6, 0, 0, 1);
      drive(0, 0, 0, 0, 20);
      drive(0, 0, 0, 1, 1);
      drive(1, 128'h3, 0, 0, 1);
      drive(0, 0, 0, 0, 3);
      drive(0, 0, 1, 0, 3);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(199) == 0);
         drive($urandom_range(9) < 7, {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(9) < 6, $urandom_range(31) == 0, 1);
      end
      rst = 0;
      drive(0, 0, 1, 0, 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
